// File: rtl/serial_to_parallel.sv
// ----------------------------------------------------------------------------
// serial_to_parallel
//   Recovers bytes from a single serial lane (MSB first). A comma symbol is
//   searched bit-by-bit until found. Byte alignment is then confirmed by
//   ALIGN_COUNT consecutive aligned commas. Once locked, every byte boundary
//   presents the received byte on data_out. The lock persists until reset.
//
// Ports
//   clk_32f   in   1   bit clock, rising edge
//   reset     in   1   asynchronous reset, active low
//   data_in   in   1   serial lane bit, MSB first per byte
//   data_out  out  8   recovered byte, held for a full byte time
//   valid_out out  1   data_out holds a non-comma payload byte
//   active    out  1   byte alignment locked
//
// State     | meaning
// ----------+-----------------------------------------------------------
// UNLOCKED  | sliding search for COM_SYMBOL on every bit
// LOCKING   | aligned, counting consecutive commas at byte boundaries
// LOCKED    | aligned for good, bytes passed to data_out at each boundary
// ----------------------------------------------------------------------------
module serial_to_parallel #(
    parameter logic [7:0] COM_SYMBOL  = 8'hBC,
    parameter int         ALIGN_COUNT = 4      // legal range 1..15
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] sr;
    logic [2:0] bc, bc_nxt;
    logic [3:0] com_cnt, com_cnt_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       active_nxt;

    // The byte completed by the bit arriving this edge; using it directly
    // puts the byte on data_out on the edge that samples its LSB.
    logic [7:0] cand;
    logic       is_com;
    logic       boundary;

    assign cand     = {sr[6:0], data_in};
    assign is_com   = (cand == COM_SYMBOL);
    assign boundary = (bc == 3'd7);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state     <= UNLOCKED;
            sr        <= 8'h00;
            bc        <= 3'd0;
            com_cnt   <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= cand;
            bc        <= bc_nxt;
            com_cnt   <= com_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            active    <= active_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bc_nxt      = bc + 3'd1;
        com_cnt_nxt = com_cnt;
        data_nxt    = data_out;
        valid_nxt   = valid_out;
        active_nxt  = active;

        case (state)
            UNLOCKED: begin
                if (is_com) begin
                    // Restart the bit counter so the next boundary falls
                    // exactly one byte after this comma.
                    bc_nxt      = 3'd0;
                    com_cnt_nxt = 4'd1;
                    if (ALIGN_COUNT == 1) begin
                        state_nxt  = LOCKED;
                        active_nxt = 1'b1;
                    end else begin
                        state_nxt = LOCKING;
                    end
                end
            end

            LOCKING: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_nxt = com_cnt + 4'd1;
                        if ((com_cnt + 4'd1) == 4'(ALIGN_COUNT)) begin
                            state_nxt  = LOCKED;
                            active_nxt = 1'b1;
                        end
                    end else begin
                        com_cnt_nxt = 4'd0;
                        state_nxt   = UNLOCKED;
                    end
                end
            end

            LOCKED: begin
                // No comma search here: commas straddling a boundary are
                // ordinary data once locked.
                if (boundary) begin
                    data_nxt  = cand;
                    valid_nxt = !is_com;
                end
            end

            default: begin
                state_nxt = UNLOCKED;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// ----------------------------------------------------------------------------
// tb_serial_to_parallel
//   Drives serial byte streams into two instances (ALIGN_COUNT 4 and 1).
//   Expected bytes are queued when driven and compared when the byte's
//   last bit has been clocked in; in between, outputs must hold.
// ----------------------------------------------------------------------------
module tb_serial_to_parallel;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out0, data_out1;
    logic       valid_out0, valid_out1;
    logic       active0, active1;

    logic       sel;
    logic [7:0] obs_d;
    logic       obs_v;
    logic       obs_a;

    logic [8:0] exp_q[$];
    logic [7:0] hold_d;
    logic       hold_v;

    int n_tests;
    int n_fail;

    serial_to_parallel #(.COM_SYMBOL(8'hBC), .ALIGN_COUNT(4)) u_dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out0),
        .valid_out (valid_out0),
        .active    (active0)
    );

    serial_to_parallel #(.COM_SYMBOL(8'hBC), .ALIGN_COUNT(1)) u_dut1 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out1),
        .valid_out (valid_out1),
        .active    (active1)
    );

    always_comb begin
        obs_d = sel ? data_out1  : data_out0;
        obs_v = sel ? valid_out1 : valid_out0;
        obs_a = sel ? active1    : active0;
    end

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},   obs_d, 8'h00);
        chk({tag, "_valid"},  obs_v, 1'b0);
        chk({tag, "_active"}, obs_a, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
        #1;
        chk_zero("rst_async");
        @(posedge clk_32f);
        #1;
        chk_zero("rst_held");
        @(negedge clk_32f);
        reset  = 1'b1;
        hold_d = 8'h00;
        hold_v = 1'b0;
        exp_q.delete();
    endtask

    // Shift raw bits (MSB of the n-bit field first) while checking hold.
    task automatic send_bits(input logic [7:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk_32f);
            data_in = bits[i];
            @(posedge clk_32f);
            #1;
            chk({tag, "_hold_d"}, obs_d, hold_d);
            chk({tag, "_hold_v"}, obs_v, hold_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit has_exp,
                             input logic [7:0] ed, input logic ev,
                             input logic ea, input string tag);
        logic [8:0] e;
        if (has_exp) exp_q.push_back({ev, ed});
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_32f);
            data_in = b[i];
            @(posedge clk_32f);
            #1;
            if (i > 0) begin
                chk({tag, "_hold_d"}, obs_d, hold_d);
                chk({tag, "_hold_v"}, obs_v, hold_v);
            end
        end
        if (has_exp && exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            hold_d = e[7:0];
            hold_v = e[8];
        end
        chk({tag, "_data"},   obs_d, hold_d);
        chk({tag, "_valid"},  obs_v, hold_v);
        chk({tag, "_active"}, obs_a, ea);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 1'b0;
        hold_d  = 8'h00;
        hold_v  = 1'b0;
        reset   = 1'b0;
        data_in = 1'b0;

        // Reset held with random serial data
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_32f);
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            chk_zero("rst_random");
        end
        @(negedge clk_32f);
        data_in = 1'b0;
        reset   = 1'b1;

        // Junk bits, 4 commas, then payload
        send_bits(8'h00, 3, "junk");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "lk_bc1");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "lk_bc2");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "lk_bc3");
        send_byte(8'hBC, 0, 8'h00, 0, 1, "lk_bc4");
        send_byte(8'hFF, 1, 8'hFF, 1, 1, "pl_ff1");
        send_byte(8'hDD, 1, 8'hDD, 1, 1, "pl_dd1");
        send_byte(8'hFF, 1, 8'hFF, 1, 1, "pl_ff2");
        send_byte(8'hDD, 1, 8'hDD, 1, 1, "pl_dd2");

        // Interrupted comma run falls back to UNLOCKED
        do_reset();
        send_byte(8'hBC, 0, 8'h00, 0, 0, "br_bc1");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "br_bc2");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "br_bc3");
        send_byte(8'hAA, 0, 8'h00, 0, 0, "br_aa");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "rl_bc1");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "rl_bc2");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "rl_bc3");
        send_byte(8'hBC, 0, 8'h00, 0, 1, "rl_bc4");
        send_byte(8'hEE, 1, 8'hEE, 1, 1, "pl_ee");

        // Commas after lock are reported as non-valid
        send_byte(8'hCA, 1, 8'hCA, 1, 1, "pl_ca");
        send_byte(8'hBC, 1, 8'hBC, 0, 1, "pl_com");
        send_byte(8'hBF, 1, 8'hBF, 1, 1, "pl_bf");

        // Comma straddling a boundary must not re-align
        send_byte(8'h0B, 1, 8'h0B, 1, 1, "st_0b");
        send_byte(8'hC0, 1, 8'hC0, 1, 1, "st_c0");
        send_byte(8'h5A, 1, 8'h5A, 1, 1, "st_5a");

        // Reset in the middle of a byte while locked
        send_bits(8'h0A, 4, "mid");
        @(negedge clk_32f);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("mid_rst_async");
        @(posedge clk_32f);
        #1;
        chk_zero("mid_rst_held");
        @(negedge clk_32f);
        data_in = 1'b0;
        reset   = 1'b1;
        hold_d  = 8'h00;
        hold_v  = 1'b0;
        exp_q.delete();
        send_byte(8'hBC, 0, 8'h00, 0, 0, "re_bc1");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "re_bc2");
        send_byte(8'hBC, 0, 8'h00, 0, 0, "re_bc3");
        send_byte(8'hBC, 0, 8'h00, 0, 1, "re_bc4");
        send_byte(8'h3C, 1, 8'h3C, 1, 1, "re_3c");

        // Single-comma lock instance
        sel = 1'b1;
        do_reset();
        send_bits(8'h00, 3, "a1_junk");
        send_byte(8'hBC, 0, 8'h00, 0, 1, "a1_bc");
        send_byte(8'h5A, 1, 8'h5A, 1, 1, "a1_5a");
        send_byte(8'hBC, 1, 8'hBC, 0, 1, "a1_com");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter COM_SYMBOL, default 8'hBC: comma/alignment symbol value.
REQ-002 Parameter ALIGN_COUNT, default 4: consecutive aligned COM_SYMBOL bytes needed to declare lock; legal range 1..15.
REQ-003 clk_32f  input  1  bit clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 data_in  input  1  serial lane bit from the PHY TX lane, MSB-first per byte.
REQ-006 data_out  output  8  recovered parallel byte.
REQ-007 valid_out  output  1  high while data_out holds a valid non-COM payload byte.
REQ-008 active  output  1  high once byte alignment is locked.

Function
REQ-009 Shift register sr[7:0] SHALL load {sr[6:0], data_in} every rising edge; the candidate byte is cand = {sr[6:0], data_in}.
REQ-010 A 3-bit bit counter bc SHALL increment each edge, wrapping 7->0; a byte boundary is an edge with bc==7.
REQ-011 A 4-bit counter com_cnt SHALL track consecutive aligned COM_SYMBOL bytes.
REQ-012 FSM states: UNLOCKED, LOCKING, LOCKED.
REQ-013 UNLOCKED: cand SHALL be compared to COM_SYMBOL on every edge (sliding); on match bc<=0, com_cnt<=1, next state LOCKING (LOCKED directly if ALIGN_COUNT==1); no match: stay, bc is don't-care.
REQ-014 LOCKING: at each byte boundary, cand==COM_SYMBOL -> com_cnt+1; when com_cnt+1==ALIGN_COUNT -> LOCKED; cand!=COM_SYMBOL -> com_cnt<=0, UNLOCKED; no action off-boundary.
REQ-015 active SHALL go high on the same edge the FSM enters LOCKED; the locking COM byte itself SHALL NOT assert valid_out.
REQ-016 LOCKED: at each byte boundary data_out<=cand; valid_out<=1 if cand!=COM_SYMBOL, else 0.
REQ-017 data_out and valid_out SHALL hold for the full 8 edges until the next boundary (slow-domain consumers sample safely).
REQ-018 Latency: a byte appears on data_out at the same rising edge its 8th (LSB) bit is sampled, i.e. registered, zero extra cycles.
REQ-019 LOCKED SHALL persist until reset; misaligned data after lock is passed through unchanged.
REQ-020 In UNLOCKED and LOCKING, data_out SHALL remain 8'h00 and valid_out 0.
REQ-021 COM_SYMBOL embedded across a boundary after lock SHALL NOT re-align.

Reset
REQ-022 reset==0 SHALL immediately (asynchronously) force sr=0, bc=0, com_cnt=0, state UNLOCKED, data_out=8'h00, valid_out=0, active=0.
REQ-023 Reset asserted mid-byte or mid-lock SHALL discard partial data; after release, alignment restarts from UNLOCKED.
REQ-024 Release of reset SHALL take effect on the first rising edge with reset==1.

Verification
REQ-025 Reset held 0 for 2 edges with random data_in -> data_out=00, valid_out=0, active=0 throughout.
REQ-026 After 3 junk bits, send BC x4 then FF,DD,FF,DD -> active rises at the edge ending 4th BC; data_out=FF,DD,FF,DD each held 8 edges with valid_out=1.
REQ-027 Send BC,BC,BC,AA,BC,BC,BC,BC,EE -> no lock after AA (back to UNLOCKED); lock after the later 4 BCs; EE output with valid_out=1.
REQ-028 Locked, send CA,BC,BF -> data_out CA(valid 1), BC(valid 0), BF(valid 1).
REQ-029 Locked stream, pull reset low at bit 3 of a byte -> all outputs 0 asynchronously; after release, relock needs 4 fresh BCs.
REQ-030 ALIGN_COUNT=1, send single BC then 5A -> active high after BC; 5A on data_out, valid_out=1.
